systolic_skew_feeder: RTL and testbench

//  Upstream stage of the N x N systolic MAC array. Accepts one K-step operand pair per handshake
//  (N top-edge values + N left-edge values), applies diagonal skew (lane m delayed m cycles), and

---
 rtl/systolic_skew_feeder.sv | 143 ++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_skew_feeder
//  Purpose  : Diagonal-skew operand feeder for an N x N systolic MAC array.
//             Optional feature macro: FEEDER_STALL_CNT_EN (adds stall_count).
//  Revision : 1.0
// ============================================================================
module systolic_skew_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4,
    parameter int K_MAX      = 16,
    localparam int KW        = $clog2(K_MAX + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [KW-1:0]         k_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*DATA_WIDTH-1:0] top_in,
    input  logic [N*DATA_WIDTH-1:0] left_in,
    output logic [N*DATA_WIDTH-1:0] top_out,
    output logic [N*DATA_WIDTH-1:0] left_out,
    output logic                  arr_clr,
    output logic                  busy,
    output logic                  done
`ifdef FEEDER_STALL_CNT_EN
   ,output logic [15:0]           stall_count
`endif
);

    localparam int              DCW          = $clog2(2 * N);
    localparam logic [KW-1:0]   C_K_MAX      = KW'(K_MAX);
    localparam logic [DCW-1:0]  C_DRAIN_LAST = DCW'(2 * N - 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [KW-1:0]   r_k_len;
    logic [KW-1:0]   r_hs_cnt;
    logic [DCW-1:0]  r_drain_cnt;
    logic [KW-1:0]   w_k_clamped;
    logic            w_hs;
    logic            w_last_hs;

    assign w_k_clamped = (k_len > C_K_MAX) ? C_K_MAX : k_len;
    assign w_hs        = in_valid && (r_state == S_STREAM);
    assign w_last_hs   = w_hs && (KW'(r_hs_cnt + KW'(1)) == r_k_len);

    assign in_ready = (r_state == S_STREAM);
    assign arr_clr  = (r_state == S_CLEAR);
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_next = S_CLEAR;
            S_CLEAR:  w_state_next = (r_k_len == '0) ? S_DONE : S_STREAM;
            S_STREAM: if (w_last_hs) w_state_next = S_DRAIN;
            S_DRAIN:  if (r_drain_cnt == C_DRAIN_LAST) w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k_len     <= '0;
            r_hs_cnt    <= '0;
            r_drain_cnt <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_k_len <= w_k_clamped;
            end
            if (r_state == S_CLEAR) begin
                r_hs_cnt <= '0;
            end else if (w_hs) begin
                r_hs_cnt <= KW'(r_hs_cnt + KW'(1));
            end
            // Drain lasts until the last operand has crossed to PE(N-1,N-1).
            if (r_state == S_DRAIN) begin
                r_drain_cnt <= DCW'(r_drain_cnt + DCW'(1));
            end else begin
                r_drain_cnt <= '0;
            end
        end
    end

    // Lane m is an (m+1)-stage shift register; non-handshake cycles inject zeros.
    generate
        for (genvar m = 0; m < N; m++) begin : g_lane
            logic [DATA_WIDTH-1:0] r_top_sr  [m+1];
            logic [DATA_WIDTH-1:0] r_left_sr [m+1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s <= m; s++) begin
                        r_top_sr[s]  <= '0;
                        r_left_sr[s] <= '0;
                    end
                end else begin
                    r_top_sr[0]  <= w_hs ? top_in[m*DATA_WIDTH +: DATA_WIDTH]  : '0;
                    r_left_sr[0] <= w_hs ? left_in[m*DATA_WIDTH +: DATA_WIDTH] : '0;
                    for (int s = 1; s <= m; s++) begin
                        r_top_sr[s]  <= r_top_sr[s-1];
                        r_left_sr[s] <= r_left_sr[s-1];
                    end
                end
            end

            assign top_out[m*DATA_WIDTH +: DATA_WIDTH]  = r_top_sr[m];
            assign left_out[m*DATA_WIDTH +: DATA_WIDTH] = r_left_sr[m];
        end
    endgenerate

`ifdef FEEDER_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || r_state == S_CLEAR) begin
            stall_count <= '0;
        end else if (r_state == S_STREAM && !in_valid && stall_count != 16'hFFFF) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_skew_feeder
//  Purpose  : Scoreboard bench for systolic_skew_feeder with an N x N MAC model.
//  Revision : 1.0
// ============================================================================
module tb_systolic_skew_feeder;

    localparam int DW    = 8;
    localparam int N     = 4;
    localparam int K_MAX = 16;
    localparam int KW    = $clog2(K_MAX + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [KW-1:0]   k_len = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N*DW-1:0] top_in = '0;
    logic [N*DW-1:0] left_in = '0;
    logic [N*DW-1:0] top_out;
    logic [N*DW-1:0] left_out;
    logic            arr_clr;
    logic            busy;
    logic            done;
`ifdef FEEDER_STALL_CNT_EN
    logic [15:0]     stall_count;
`endif

    systolic_skew_feeder #(.DATA_WIDTH(DW), .N(N), .K_MAX(K_MAX)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready),
        .top_in(top_in), .left_in(left_in),
        .top_out(top_out), .left_out(left_out),
        .arr_clr(arr_clr), .busy(busy), .done(done)
`ifdef FEEDER_STALL_CNT_EN
       ,.stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;
    int last_hs = 0;

    typedef struct {int cyc; int lane; int t; int l;} ev_t;
    ev_t evq[$];
    int  clrq[$];
    int  doneq[$];

    int exp_acc [N][N];
    int acc     [N][N];
    int a_r     [N][N];
    int b_r     [N][N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: per-cycle lane/control scoreboard plus a behavioural MAC array fed by the DUT.
    always @(negedge clk) begin : monitor
        int et [N];
        int el [N];
        int na [N][N];
        int nb [N][N];
        logic e_clr;
        logic e_done;
        if (mon_en) begin
            for (int m = 0; m < N; m++) begin
                et[m] = 0;
                el[m] = 0;
            end
            for (int k = evq.size() - 1; k >= 0; k--) begin
                if (evq[k].cyc == cyc) begin
                    et[evq[k].lane] = evq[k].t;
                    el[evq[k].lane] = evq[k].l;
                    evq.delete(k);
                end
            end
            for (int m = 0; m < N; m++) begin
                chk($sformatf("top_lane%0d", m),  32'(top_out[m*DW +: DW]),  et[m]);
                chk($sformatf("left_lane%0d", m), 32'(left_out[m*DW +: DW]), el[m]);
            end
            e_clr = (clrq.size() > 0 && clrq[0] == cyc);
            if (e_clr) void'(clrq.pop_front());
            chk("arr_clr", 32'(arr_clr), 32'(e_clr));
            e_done = (doneq.size() > 0 && doneq[0] == cyc);
            if (e_done) void'(doneq.pop_front());
            chk("done", 32'(done), 32'(e_done));
            if (e_done && done) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        chk($sformatf("p_sum_%0d_%0d", i, j), acc[i][j], exp_acc[i][j]);
            end
            if (arr_clr) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        acc[i][j] = 0; a_r[i][j] = 0; b_r[i][j] = 0;
                    end
            end else begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        na[i][j] = (i == 0) ? int'(top_out[j*DW +: DW])  : a_r[i-1][j];
                        nb[i][j] = (j == 0) ? int'(left_out[i*DW +: DW]) : b_r[i][j-1];
                        acc[i][j] += na[i][j] * nb[i][j];
                    end
                a_r = na;
                b_r = nb;
            end
        end
    end

    task automatic start_tile(input int k);
        @(posedge clk); #1;
        start = 1'b1;
        k_len = KW'(k);
        @(negedge clk);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) exp_acc[i][j] = 0;
        clrq.push_back(cyc + 1);
        if (k == 0) doneq.push_back(cyc + 2);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [N*DW-1:0] t, input logic [N*DW-1:0] l);
        int  guard = 0;
        bit  hs = 1'b0;
        top_in   = t;
        left_in  = l;
        in_valid = 1'b1;
        while (!hs && guard < 50) begin
            @(negedge clk);
            if (in_ready) begin
                hs = 1'b1;
                last_hs = cyc;
                for (int m = 0; m < N; m++)
                    evq.push_back('{cyc + 1 + m, m, int'(t[m*DW +: DW]), int'(l[m*DW +: DW])});
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        exp_acc[i][j] += int'(t[j*DW +: DW]) * int'(l[i*DW +: DW]);
            end
            @(posedge clk); #1;
            guard++;
        end
        if (!hs) chk("handshake_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        top_in   = '0;
        left_in  = '0;
    endtask

    task automatic wait_done();
        int n = 0;
        doneq.push_back(last_hs + 2 * N);
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        if (!done) chk("done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        // 1: reset for three cycles, then idle outputs
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_top_out",  top_out,  32'd0);
        chk("rst_left_out", left_out, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_arr_clr",  32'(arr_clr),  32'd0);
        mon_en = 1'b1;

        // 2: k=4, all ones, back-to-back -> every p_sum = 4
        start_tile(4);
        repeat (4) send(32'h01010101, 32'h01010101);
        wait_done();
`ifdef FEEDER_STALL_CNT_EN
        chk("stall_count_t2", 32'(stall_count), 32'd0);
`endif

        // 3: k=1, distinct lane values
        start_tile(1);
        send(32'h04030201, 32'h08070605);
        wait_done();

        // 4: k=3 with a two-cycle bubble between steps 1 and 2
        start_tile(3);
        send(32'h04030201, 32'h01010101);
        @(posedge clk); #1;
        @(posedge clk); #1;
        send(32'h05060708, 32'h02000301);
        send(32'h10203040, 32'h03020100);
        wait_done();
`ifdef FEEDER_STALL_CNT_EN
        chk("stall_count_t4", 32'(stall_count), 32'd2);
`endif

        // 5a: k=0 -> clear then done, in_ready never rises
        start_tile(0);
        repeat (4) begin
            @(negedge clk);
            chk("in_ready_k0", 32'(in_ready), 32'd0);
        end
        // 5b: start pulse during STREAM must be ignored
        start_tile(2);
        send(32'h01020304, 32'h05060708);
        start = 1'b1;
        k_len = KW'(7);
        @(posedge clk); #1;
        start = 1'b0;
        send(32'h0A0B0C0D, 32'h01010101);
        wait_done();
        chk("busy_after_done", 32'(busy), 32'd0);

        // Clamp: k_len above K_MAX runs exactly K_MAX steps
        start_tile(20);
        repeat (K_MAX) send(32'h01010101, 32'h02020202);
        wait_done();

        // 6: reset mid-STREAM after two handshakes
        start_tile(4);
        send(32'h11111111, 32'h22222222);
        send(32'h33333333, 32'h44444444);
        rst = 1'b1;
        @(negedge clk);
        for (int k = evq.size() - 1; k >= 0; k--)
            if (evq[k].cyc > cyc) evq.delete(k);
        doneq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_busy",     32'(busy),     32'd0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mid_top",      top_out,       32'd0);
        chk("rst_mid_left",     left_out,      32'd0);
        repeat (12) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
